// File: rtl/pc_pass_monitor.sv
// PC pass monitor: watches the core PC after arming and reports pass or timeout.
// Optional FAIL_ADDR trap state and fail output when PC_MON_FAIL_EN is defined.
module pc_pass_monitor #(
    parameter logic [31:0] PASS_ADDR  = 32'h0000_06B4,
    parameter logic [31:0] LAST_ADDR  = 32'h0000_0694,
    parameter int unsigned CHECK_LAST = 1,
`ifdef PC_MON_FAIL_EN
    parameter logic [31:0] FAIL_ADDR  = 32'h0000_0000,
`endif
    parameter logic [31:0] MAX_CYCLES = 32'd2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic [31:0] pc_current,
    output logic        done,
    output logic        pass,
    output logic        timeout,
`ifdef PC_MON_FAIL_EN
    output logic        fail,
`endif
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        TIMEOUT
`ifdef PC_MON_FAIL_EN
        , FAIL
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] prevPc_q;
    logic [31:0] cycleCount_q;
    logic        done_q;
    logic        pass_q;
    logic        timeout_q;
    logic [31:0] countInc_d;
    logic        passHit_d;
    logic        failHit_d;
    logic        timeHit_d;

    // All RUN decisions are made against the already-incremented count.
    always_comb begin
        countInc_d = cycleCount_q + 32'd1;
        passHit_d  = (pc_current == PASS_ADDR) &&
                     ((CHECK_LAST == 0) || (prevPc_q == LAST_ADDR));
        timeHit_d  = (countInc_d == MAX_CYCLES);
`ifdef PC_MON_FAIL_EN
        failHit_d  = (FAIL_ADDR != 32'h0) && (pc_current == FAIL_ADDR);
`else
        failHit_d  = 1'b0;
`endif
    end

`ifdef PC_MON_FAIL_EN
    logic fail_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prevPc_q     <= 32'h0;
            cycleCount_q <= 32'h0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef PC_MON_FAIL_EN
            fail_q       <= 1'b0;
`endif
        end else if (clear) begin
            state_q      <= IDLE;
            cycleCount_q <= 32'h0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef PC_MON_FAIL_EN
            fail_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= RUN;
                        prevPc_q     <= pc_current;
                        cycleCount_q <= 32'h0;
                    end
                end
                RUN: begin
                    cycleCount_q <= countInc_d;
                    prevPc_q     <= pc_current;
                    // Priority on a shared edge: pass, then fail, then timeout.
                    if (passHit_d) begin
                        state_q <= PASS;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
`ifdef PC_MON_FAIL_EN
                    end else if (failHit_d) begin
                        state_q <= FAIL;
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
`endif
                    end else if (timeHit_d) begin
                        state_q   <= TIMEOUT;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycleCount_q;
`ifdef PC_MON_FAIL_EN
    assign fail        = fail_q;
`else
    logic unusedFail;
    assign unusedFail = failHit_d;
`endif

endmodule

// File: doc/pc_pass_monitor.md
PC_PASS_MONITOR -- requirements
Module: pc_pass_monitor

Interface
REQ-001 SHALL have parameter PASS_ADDR, default 32'h0000_06B4: PC value that signals test pass.
REQ-002 SHALL have parameter LAST_ADDR, default 32'h0000_0694: PC value required in the cycle before PASS_ADDR.
REQ-003 SHALL have parameter CHECK_LAST, default 1: 1 means pass needs the LAST_ADDR->PASS_ADDR transition; 0 means any arrival at PASS_ADDR (fallback).
REQ-004 SHALL have parameter MAX_CYCLES, default 2000: timeout limit in sampled cycles; legal range 1..2^32-1.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: arm pulse; sampled only in IDLE.
REQ-008 SHALL have port clear, input, 1: return from PASS/TIMEOUT/FAIL to IDLE.
REQ-009 SHALL have port pc_current, input, 32: core PC, sampled every cycle.
REQ-010 SHALL have port done, output, 1: high in PASS, TIMEOUT or FAIL.
REQ-011 SHALL have port pass, output, 1: high only in PASS.
REQ-012 SHALL have port timeout, output, 1: high only in TIMEOUT.
REQ-013 SHALL have port cycle_count, output, 32: cycles sampled since arming; frozen once done.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PASS, TIMEOUT (and FAIL when configured); outputs are registered decodes of the state.
REQ-015 IDLE: on start=1, go to RUN next edge, load prev_pc<=pc_current, cycle_count<=0.
REQ-016 RUN, each edge: cycle_count<=cycle_count+1, prev_pc<=pc_current; the comparisons use the incremented count.
REQ-017 RUN pass condition: pc_current==PASS_ADDR and (CHECK_LAST==0 or prev_pc==LAST_ADDR) -> PASS on that edge.
REQ-018 RUN timeout: incremented count==MAX_CYCLES with no pass condition -> TIMEOUT; pass condition on that same edge wins (PASS).
REQ-019 PASS/TIMEOUT/FAIL SHALL be sticky; cycle_count and prev_pc hold; pc_current ignored.
REQ-020 clear=1 in any state SHALL go to IDLE next edge and zero cycle_count; clear has priority over start and over all RUN transitions.
REQ-021 start asserted outside IDLE SHALL be ignored; start held high after clear re-arms on the next IDLE edge.
REQ-022 pass-to-done latency: done/pass high one edge after the cycle pc_current first shows the qualifying PASS_ADDR.
REQ-023 cycle_count SHALL not wrap: saturates at MAX_CYCLES by construction.

Reset
REQ-024 rst=1 SHALL force immediately, independent of clk: state=IDLE, cycle_count=0, prev_pc=0, done=0, pass=0, timeout=0, fail=0.
REQ-025 rst asserted mid-RUN SHALL abort the run without reporting; after rst release the block waits for a new start.

Configuration
REQ-026 Macro PC_MON_FAIL_EN defined: adds parameter FAIL_ADDR (default 32'h0000_0000, 0 disables) and output fail (1 bit); in RUN pc_current==FAIL_ADDR (FAIL_ADDR!=0) goes to FAIL, done=1; on one edge priority PASS > FAIL > TIMEOUT.
REQ-027 Macro PC_MON_FAIL_EN undefined: no FAIL state, no FAIL_ADDR, no fail port; behaviour exactly REQ-014..REQ-025.

Verification
REQ-028 start, then pc 0x690,0x694,0x6B4 on successive cycles -> pass=1,done=1 one edge after 0x6B4 sampled, cycle_count=3.
REQ-029 CHECK_LAST=1, pc jumps 0x600->0x6B4 -> no pass; MAX_CYCLES=10 with pc stuck -> timeout=1 with cycle_count=10, pass=0.
REQ-030 CHECK_LAST=0, pc 0x600->0x6B4 -> pass=1, cycle_count=2; then clear=1 -> IDLE, done=0, cycle_count=0 next edge.
REQ-031 MAX_CYCLES=5, transition 0x694->0x6B4 with 0x6B4 on cycle 5 -> pass=1, timeout=0.
REQ-032 rst pulse (between edges) mid-RUN at cycle_count=7 -> all outputs 0 immediately; later 0x694->0x6B4 without start -> pass stays 0.
REQ-033 PC_MON_FAIL_EN, FAIL_ADDR=0x6C0: pc reaches 0x6C0 -> fail=1, done=1, pass=0; built without macro, same stimulus -> runs to timeout.
